sync_event_arb: RTL and testbench

// - Collects N_CH asynchronous event lines (GPIO, peripheral IRQs from foreign domains) into clk_i.
// - Synchronizes each line and detects its rising edge; a sync_pulse instance does this per channel.
// - Latches each event as pending; counts events lost while pending; hands pending events one at a

---
 rtl/sync_pkg.sv | 11 +
 rtl/sync_pulse.sv | 55 +++++
 rtl/sync_event_arb.sv | 162 ++++++++++++++++
 tb/tb_sync_event_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared types for the event synchronizer/arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package sync_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } sync_arb_state_e;

endpackage

// File: rtl/sync_pulse.sv
// Level synchronizer + rising-edge detector producing a PULSE_WIDTH-cycle pulse.
// Latency: input high at edge 1 -> pulse_o high after edge SYNC_DEPTH.
// Backpressure: none; free-running, pulses cannot be stalled.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   d_i      asynchronous level input
//   pulse_o  pulse on each synchronized rising edge of d_i
module sync_pulse #(
    parameter int   PULSE_WIDTH = 1,
    parameter int   SYNC_DEPTH  = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    localparam int CW = $clog2(PULSE_WIDTH + 1);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rise;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], d_i};
        prev_d = sync_q[SYNC_DEPTH-1];
        rise   = sync_q[SYNC_DEPTH-1] & ~prev_q;
        cnt_d  = cnt_q;
        // The edge cycle itself is the first pulse cycle; the counter covers the rest.
        if (rise) begin
            cnt_d = CW'(PULSE_WIDTH - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign pulse_o = rise | (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sync_event_arb.sv
// Synchronizes N_CH async event lines, latches them as pending and offers them round-robin.
// Latency: evt_i high at edge 1 -> pend_o after edge SYNC_DEPTH+1, evt_valid_o after SYNC_DEPTH+2.
// Backpressure: valid/ready; offer held until accepted, re-arrivals while pending are counted as lost.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   evt_i[N_CH]          async event lines (rising edge = event)
//   en_i[N_CH]           per-channel enable
//   evt_valid_o/_ready_i consumer handshake; evt_id_o is the offered channel
//   pend_o[N_CH]         pending flags
//   ovf_o[N_CH]          sticky lost-event flags, cleared by ovf_clr_i strobes
//   ovf_cnt_o            saturating total of lost events
module sync_event_arb
    import sync_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SYNC_DEPTH = 2,
    parameter int OVF_CNT_W  = 8,
    localparam int IDW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_CH-1:0]      evt_i,
    input  logic [N_CH-1:0]      en_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [IDW-1:0]       evt_id_o,
    output logic [N_CH-1:0]      pend_o,
    output logic [N_CH-1:0]      ovf_o,
    input  logic [N_CH-1:0]      ovf_clr_i,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

    localparam int                 SW      = OVF_CNT_W + IDW + 1;
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};

    // Search starts just after the last served channel and wraps, so every
    // enabled pending channel is reached within N_CH grants.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = IDW'((int'(last) + k) % N_CH);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [N_CH-1:0] pe;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        sync_pulse #(
            .PULSE_WIDTH (1),
            .SYNC_DEPTH  (SYNC_DEPTH),
            .RST_VAL     (1'b0)
        ) u_sync (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .d_i     (evt_i[g]),
            .pulse_o (pe[g])
        );
    end

    sync_arb_state_e      state_q, state_d;
    logic                 valid_q, valid_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [N_CH-1:0]      pend_q, pend_d;
    logic [N_CH-1:0]      ovf_q, ovf_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic                 hs;
    logic [N_CH-1:0]      req;
    logic [N_CH-1:0]      clr_vec;
    logic [N_CH-1:0]      ovf_evt;
    logic [SW-1:0]        cnt_sum;

    always_comb begin
        hs  = (state_q == ARB_OFFER) & valid_q & evt_ready_i;
        req = pend_q & en_i;

        clr_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr_vec[i] = hs && (id_q == IDW'(i));
        end

        // A channel whose pending bit is being consumed this cycle can accept
        // a fresh event without it counting as lost.
        ovf_evt = pe & en_i & pend_q & ~clr_vec;
        pend_d  = (pend_q & ~clr_vec) | (pe & en_i);
        ovf_d   = (ovf_q & ~ovf_clr_i) | ovf_evt;

        cnt_sum = SW'(ovf_cnt_q) + SW'($countones(ovf_evt));
        if (cnt_sum > SW'(CNT_MAX)) begin
            ovf_cnt_d = CNT_MAX;
        end else begin
            ovf_cnt_d = cnt_sum[OVF_CNT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req != '0) begin
                    id_d    = rr_pick(req, last_q);
                    valid_d = 1'b1;
                    state_d = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                // Offer is never withdrawn, even if the channel gets disabled.
                if (hs) begin
                    last_d  = id_q;
                    valid_d = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            last_q    <= IDW'(N_CH - 1);
            pend_q    <= '0;
            ovf_q     <= '0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign pend_o      = pend_q;
    assign ovf_o       = ovf_q;
    assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: tb/tb_sync_event_arb.sv
// Randomized self-checking bench for sync_event_arb against a behavioural model.
// Latency: n/a.
// Backpressure: evt_ready_i driven randomly and in directed hold sequences.
module tb_sync_event_arb;

    localparam int N  = 4;
    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [3:0] evt, en, clr;
    logic       rdy;

    logic       valid_a, valid_b;
    logic [1:0] id_a, id_b;
    logic [3:0] pend_a, pend_b, ovf_a, ovf_b, clr_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    sync_event_arb #(.N_CH(N), .SYNC_DEPTH(SD), .OVF_CNT_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .evt_i(evt), .en_i(en),
        .evt_valid_o(valid_a), .evt_ready_i(rdy), .evt_id_o(id_a),
        .pend_o(pend_a), .ovf_o(ovf_a), .ovf_clr_i(clr), .ovf_cnt_o(cnt_a)
    );

    // Narrow-counter instance sees identical stimulus; only its counter is checked.
    assign clr_b = clr;
    sync_event_arb #(.N_CH(N), .SYNC_DEPTH(SD), .OVF_CNT_W(2)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .evt_i(evt), .en_i(en),
        .evt_valid_o(valid_b), .evt_ready_i(rdy), .evt_id_o(id_b),
        .pend_o(pend_b), .ovf_o(ovf_b), .ovf_clr_i(clr_b), .ovf_cnt_o(cnt_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] hist[$];   // sampled evt_i history, [0] = most recent edge
    bit   [3:0] m_pend, m_ovf;
    int         m_cnt8, m_cnt2;
    bit         m_valid;
    int         m_id, m_last;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i <= SD; i++) hist.push_back(4'b0);
        m_pend = '0; m_ovf = '0; m_cnt8 = 0; m_cnt2 = 0;
        m_valid = 1'b0; m_id = 0; m_last = N - 1;
    endtask

    // Predicts state after the next rising edge from current state and inputs.
    task automatic model_step();
        bit [3:0] pe, np, no, lostv;
        int lost;
        pe    = hist[SD-1] & ~hist[SD];
        np    = m_pend;
        lostv = '0;
        lost  = 0;
        for (int i = 0; i < N; i++) begin
            bit ev;
            ev = pe[i] && en[i];
            if (m_valid && rdy && m_id == i) begin
                np[i] = ev;
            end else if (ev) begin
                if (m_pend[i]) begin lostv[i] = 1'b1; lost++; end
                else np[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++)
            no[i] = lostv[i] ? 1'b1 : (clr[i] ? 1'b0 : m_ovf[i]);
        m_cnt8 = sat(m_cnt8 + lost, 255);
        m_cnt2 = sat(m_cnt2 + lost, 3);
        if (m_valid) begin
            if (rdy) begin m_valid = 1'b0; m_last = m_id; end
        end else begin
            bit [3:0] rq;
            bit found;
            rq = m_pend & en;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!found && rq[c]) begin found = 1'b1; m_id = c; m_valid = 1'b1; end
            end
        end
        m_pend = np;
        m_ovf  = no;
        hist.push_front(evt);
        hist.pop_back();
    endtask

    task automatic compare_all();
        chk("valid", {31'b0, valid_a}, {31'b0, m_valid});
        chk("id", {30'b0, id_a}, m_id);
        chk("pend", {28'b0, pend_a}, {28'b0, m_pend});
        chk("ovf", {28'b0, ovf_a}, {28'b0, m_ovf});
        chk("ovf_cnt", {24'b0, cnt_a}, m_cnt8);
        chk("ovf_cnt_sat", {30'b0, cnt_b}, m_cnt2);
    endtask

    task automatic tick(input logic [3:0] e, input logic [3:0] n, input logic r, input logic [3:0] c);
        @(negedge clk);
        compare_all();
        evt = e; en = n; rdy = r; clr = c;
        model_step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, {31'b0, valid_a}, 32'd0);
        chk({tag, "_id"}, {30'b0, id_a}, 32'd0);
        chk({tag, "_pend"}, {28'b0, pend_a}, 32'd0);
        chk({tag, "_ovf"}, {28'b0, ovf_a}, 32'd0);
        chk({tag, "_cnt"}, {24'b0, cnt_a}, 32'd0);
    endtask

    // Asserts reset between edges, checks outputs clear immediately, releases on a negedge.
    task automatic reset_pulse();
        #2 rst_ni = 1'b0;
        #1 check_reset_values("rst_async");
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_reset_values("rst_hold");
        end
        @(negedge clk);
        rst_ni = 1'b1;
        model_step();
    endtask

    function automatic logic [3:0] rmask(input int pct);
        logic [3:0] m;
        for (int i = 0; i < N; i++) m[i] = ($urandom_range(99) < pct);
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        evt = '0; en = '1; rdy = 1'b0; clr = '0;
        model_reset();
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        model_step();

        // single edge on channel 2
        repeat (3) tick(4'h4, 4'hF, 1'b1, 4'h0);
        repeat (6) tick(4'h0, 4'hF, 1'b1, 4'h0);

        // all channels rise together
        repeat (12) tick(4'hF, 4'hF, 1'b1, 4'h0);
        repeat (2)  tick(4'h0, 4'hF, 1'b1, 4'h0);

        // two edges on channel 1 while stalled, then clear the sticky flag
        repeat (3) tick(4'h2, 4'hF, 1'b0, 4'h0);
        repeat (2) tick(4'h0, 4'hF, 1'b0, 4'h0);
        repeat (3) tick(4'h2, 4'hF, 1'b0, 4'h0);
        tick(4'h2, 4'hF, 1'b0, 4'h2);
        repeat (2) tick(4'h2, 4'hF, 1'b0, 4'h0);
        repeat (3) tick(4'h0, 4'hF, 1'b1, 4'h0);

        // disabled channel 3 edge is dropped
        repeat (5) tick(4'h8, 4'h7, 1'b1, 4'h0);
        repeat (2) tick(4'h0, 4'h7, 1'b1, 4'h0);

        // channel 1 pending but masked, then re-enabled
        repeat (4) tick(4'h3, 4'hF, 1'b0, 4'h0);
        repeat (6) tick(4'h0, 4'hD, 1'b1, 4'h0);
        repeat (4) tick(4'h0, 4'hF, 1'b1, 4'h0);

        // channel 2 offer held, new edge lands on the handshake cycle
        repeat (4)  tick(4'h4, 4'hF, 1'b0, 4'h0);
        repeat (10) tick(4'h0, 4'hF, 1'b0, 4'h0);
        tick(4'h4, 4'hF, 1'b0, 4'h0);
        tick(4'h4, 4'hF, 1'b0, 4'h0);
        tick(4'h4, 4'hF, 1'b1, 4'h0);
        repeat (2) tick(4'h4, 4'hF, 1'b0, 4'h0);
        repeat (4) tick(4'h0, 4'hF, 1'b1, 4'h0);

        // reset in the middle of an offer
        repeat (5) tick(4'hF, 4'hF, 1'b0, 4'h0);
        @(negedge clk);
        compare_all();
        chk("pre_rst_valid", {31'b0, valid_a}, 32'd1);
        reset_pulse();
        repeat (10) tick(4'hF, 4'hF, 1'b1, 4'h0);
        repeat (3)  tick(4'h0, 4'hF, 1'b1, 4'h0);

        // randomized phases: {evt toggle %, enable %, ready %, clear %}
        for (int p = 0; p < 5; p++) begin
            int tgl, enp, rdp, clp;
            case (p)
                0: begin tgl = 30; enp = 100; rdp = 80; clp = 5;  end
                1: begin tgl = 50; enp = 90;  rdp = 20; clp = 10; end
                2: begin tgl = 60; enp = 100; rdp = 5;  clp = 0;  end
                3: begin tgl = 20; enp = 60;  rdp = 50; clp = 20; end
                default: begin tgl = 40; enp = 80; rdp = 60; clp = 10; end
            endcase
            for (int c = 0; c < 400; c++) begin
                tick(evt ^ rmask(tgl), rmask(enp), ($urandom_range(99) < rdp), rmask(clp));
                if (p == 4 && c == 200) reset_pulse();
            end
        end

        @(negedge clk);
        compare_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
